// File: rtl/sdcfifo_wr_packer.sv
// sdcfifo_wr_packer
// Write-side front end for the flagless register dual-clock FIFO (WCLK domain).
// Packs IW-bit samples into DW-bit words (lane 0 in the LSBs) and drives the
// FIFO's enq/din/WRST. Each sof restarts the frame and pulses WRST. At most
// LEN = 1<<LEN_LOG words are enqueued per frame; extra words set the sticky ovf.
//
// Optional feature macro: PAD_FLUSH_EN
//   When defined, an eof that leaves a partial word flushes it zero-padded,
//   subject to the same LEN cap and ovf rule. When undefined, the partial
//   word at eof is discarded silently.
//
// Handshake: there is no back-pressure. ivld qualifies idat in the cycle it is
// high; enq qualifies din in the cycle it is high and must be consumed then.
//
// state_o exposes the FSM state (0=IDLE, 1=FILL, 2=DONE) for debug/checking.
module sdcfifo_wr_packer #(
    parameter int IW      = 8,
    parameter int DW      = 32,
    parameter int LEN_LOG = 2
) (
    input  logic               WCLK,
    input  logic               RST_X,
    input  logic               sof,
    input  logic               eof,
    input  logic               ivld,
    input  logic [IW-1:0]      idat,
    output logic               WRST,
    output logic               enq,
    output logic [DW-1:0]      din,
    output logic [LEN_LOG:0]   wcnt,
    output logic               ovf,
    output logic               busy,
    output logic [1:0]         state_o
);

    localparam int RATIO = DW / IW;
    localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LW-1:0]    LANE_LAST = LW'(RATIO - 1);
    localparam logic [LEN_LOG:0] LEN_V     = (LEN_LOG + 1)'(1 << LEN_LOG);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [LEN_LOG:0] wcnt_q, wcnt_d;
    logic             ovf_q, ovf_d;
    logic             enq_q, enq_d;
    logic [DW-1:0]    din_q, din_d;
    logic             wrst_q, wrst_d;

    // Per-cycle working values of the combinational process.
    logic [DW-1:0]    word_v;
    logic [LW-1:0]    lane_nx;
    logic             push_v;

    // Next-state, packing and LEN-capped enqueue decision.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        acc_d   = acc_q;
        wcnt_d  = wcnt_q;
        ovf_d   = ovf_q;
        enq_d   = 1'b0;
        din_d   = din_q;
        wrst_d  = 1'b0;
        word_v  = acc_q;
        lane_nx = lane_q;
        push_v  = 1'b0;

        if (sof) begin
            // New frame: any partial word is dropped; a same-cycle sample
            // becomes lane 0 of the new frame.
            state_d = ST_FILL;
            wrst_d  = 1'b1;
            wcnt_d  = '0;
            ovf_d   = 1'b0;
            acc_d   = '0;
            lane_d  = '0;
            if (ivld) begin
                acc_d[IW-1:0] = idat;
                lane_d        = LW'(1);
            end
        end else if (state_q == ST_FILL) begin
            if (ivld) begin
                // Starting a word clears the upper lanes so a flushed
                // partial word is zero-padded.
                if (lane_q == '0) begin
                    word_v = '0;
                end
                word_v[lane_q*IW +: IW] = idat;
                if (lane_q == LANE_LAST) begin
                    lane_nx = '0;
                    push_v  = 1'b1;
                end else begin
                    lane_nx = lane_q + 1'b1;
                end
            end
            acc_d  = word_v;
            lane_d = lane_nx;

            if (eof) begin
                state_d = ST_DONE;
                lane_d  = '0;
`ifdef PAD_FLUSH_EN
                if (lane_nx != '0) begin
                    push_v = 1'b1;
                end
`endif
            end

            if (push_v) begin
                if (wcnt_q < LEN_V) begin
                    enq_d  = 1'b1;
                    din_d  = word_v;
                    wcnt_d = wcnt_q + 1'b1;
                end else begin
                    ovf_d  = 1'b1;
                end
            end
        end
    end

    // State and output registers; async active-low reset.
    always_ff @(posedge WCLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            acc_q   <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
            enq_q   <= 1'b0;
            din_q   <= '0;
            wrst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            acc_q   <= acc_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
            enq_q   <= enq_d;
            din_q   <= din_d;
            wrst_q  <= wrst_d;
        end
    end

    assign WRST    = wrst_q;
    assign enq     = enq_q;
    assign din     = din_q;
    assign wcnt    = wcnt_q;
    assign ovf     = ovf_q;
    assign busy    = (state_q == ST_FILL);
    assign state_o = state_q;

endmodule

// File: tb/tb_sdcfifo_wr_packer.sv
// Directed testbench for sdcfifo_wr_packer (IW=8, DW=32, LEN_LOG=2).
module tb_sdcfifo_wr_packer;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic        WCLK;
    logic        RST_X;
    logic        sof, eof, ivld;
    logic [7:0]  idat;
    logic        WRST, enq, ovf, busy;
    logic [31:0] din;
    logic [2:0]  wcnt;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;
    int enq_cnt;

    sdcfifo_wr_packer #(.IW(8), .DW(32), .LEN_LOG(2)) dut (
        .WCLK    (WCLK),
        .RST_X   (RST_X),
        .sof     (sof),
        .eof     (eof),
        .ivld    (ivld),
        .idat    (idat),
        .WRST    (WRST),
        .enq     (enq),
        .din     (din),
        .wcnt    (wcnt),
        .ovf     (ovf),
        .busy    (busy),
        .state_o (state_o)
    );

    // Clock
    initial WCLK = 1'b0;
    always #5 WCLK = ~WCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; returns 1 time unit after the edge that sampled it.
    task automatic step(input logic s, input logic e, input logic v, input logic [7:0] d);
        sof  = s;
        eof  = e;
        ivld = v;
        idat = d;
        @(posedge WCLK);
        #1;
        sof  = 1'b0;
        eof  = 1'b0;
        ivld = 1'b0;
        idat = 8'h00;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wrst"},  WRST,    1'b0);
        chk({tag, "_enq"},   enq,     1'b0);
        chk({tag, "_din"},   din,     32'h0);
        chk({tag, "_wcnt"},  wcnt,    3'd0);
        chk({tag, "_ovf"},   ovf,     1'b0);
        chk({tag, "_busy"},  busy,    1'b0);
        chk({tag, "_state"}, state_o, S_IDLE);
    endtask

    initial begin
        RST_X = 1'b0;
        sof = 1'b0; eof = 1'b0; ivld = 1'b0; idat = 8'h00;
        repeat (2) @(posedge WCLK);
        #1;
        chk_reset_vals("rst");
        RST_X = 1'b1;

        // ---- 1: basic word ----
        step(1, 0, 0, 8'h00);
        chk("t1_wrst", WRST, 1'b1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_enq_sof", enq, 1'b0);
        step(0, 0, 1, 8'h11);
        chk("t1_wrst_once", WRST, 1'b0);
        step(0, 0, 1, 8'h22);
        step(0, 0, 1, 8'h33);
        chk("t1_enq_early", enq, 1'b0);
        step(0, 0, 1, 8'h44);
        chk("t1_enq", enq, 1'b1);
        chk("t1_din", din, 32'h44332211);
        chk("t1_wcnt", wcnt, 3'd1);
        step(0, 0, 0, 8'h00);
        chk("t1_enq_pulse", enq, 1'b0);
        chk("t1_din_hold", din, 32'h44332211);

        // ---- 2: overflow after LEN words ----
        step(1, 0, 0, 8'h00);
        chk("t2_wrst", WRST, 1'b1);
        chk("t2_wcnt_clr", wcnt, 3'd0);
        enq_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 8'(i));
            if (enq) enq_cnt++;
            chk($sformatf("t2_enq_%0d", i), enq, ((i % 4 == 3) && (i < 16)) ? 1'b1 : 1'b0);
            chk($sformatf("t2_ovf_%0d", i), ovf, (i >= 19) ? 1'b1 : 1'b0);
            if ((i % 4 == 3) && (i < 16))
                chk($sformatf("t2_din_%0d", i), din,
                    {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
        end
        chk("t2_enq_cnt", enq_cnt, 4);
        chk("t2_wcnt", wcnt, 3'd4);
        chk("t2_ovf", ovf, 1'b1);

        // ---- 3: eof with partial word ----
        step(1, 0, 0, 8'h00);
        chk("t3_ovf_clr", ovf, 1'b0);
        step(0, 0, 1, 8'hA0);
        step(0, 0, 1, 8'hA1);
        step(0, 0, 1, 8'hA2);
        step(0, 0, 1, 8'hA3);
        chk("t3_enq1", enq, 1'b1);
        chk("t3_din1", din, 32'hA3A2A1A0);
        step(0, 0, 1, 8'hA4);
        step(0, 1, 1, 8'hA5);
`ifdef PAD_FLUSH_EN
        chk("t3_flush_enq", enq, 1'b1);
        chk("t3_flush_din", din, 32'h0000A5A4);
        chk("t3_wcnt", wcnt, 3'd2);
`else
        chk("t3_flush_enq", enq, 1'b0);
        chk("t3_din_hold", din, 32'hA3A2A1A0);
        chk("t3_wcnt", wcnt, 3'd1);
`endif
        chk("t3_ovf", ovf, 1'b0);
        chk("t3_state", state_o, S_DONE);
        chk("t3_busy", busy, 1'b0);
        // Samples and eof in DONE are ignored.
        for (int i = 0; i < 4; i++) begin
            step(0, (i == 3) ? 1'b1 : 1'b0, 1, 8'hE0);
            chk($sformatf("t3_done_enq_%0d", i), enq, 1'b0);
        end
        chk("t3_done_state", state_o, S_DONE);

        // ---- 4: sof mid-word while overflowed ----
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 22; i++) step(0, 0, 1, 8'(i));
        chk("t4_pre_ovf", ovf, 1'b1);
        chk("t4_pre_wcnt", wcnt, 3'd4);
        step(1, 0, 0, 8'h00);
        chk("t4_wrst", WRST, 1'b1);
        chk("t4_ovf_clr", ovf, 1'b0);
        chk("t4_wcnt_clr", wcnt, 3'd0);
        step(0, 0, 1, 8'h51);
        step(0, 0, 1, 8'h52);
        step(0, 0, 1, 8'h53);
        step(0, 0, 1, 8'h54);
        chk("t4_enq", enq, 1'b1);
        chk("t4_din", din, 32'h54535251);
        chk("t4_wcnt", wcnt, 3'd1);
        // sof with a same-cycle sample: that sample is lane 0.
        step(1, 0, 1, 8'h61);
        chk("t4b_wrst", WRST, 1'b1);
        chk("t4b_enq", enq, 1'b0);
        step(0, 0, 1, 8'h62);
        step(0, 0, 1, 8'h63);
        step(0, 0, 1, 8'h64);
        chk("t4b_enq2", enq, 1'b1);
        chk("t4b_din", din, 32'h64636261);
        // eof with a same-cycle completing sample: word enqueued, no flush.
        step(0, 0, 1, 8'h71);
        step(0, 0, 1, 8'h72);
        step(0, 0, 1, 8'h73);
        step(0, 1, 1, 8'h74);
        chk("t4c_enq", enq, 1'b1);
        chk("t4c_din", din, 32'h74737271);
        chk("t4c_wcnt", wcnt, 3'd2);
        step(0, 0, 0, 8'h00);
        chk("t4c_no_flush", enq, 1'b0);
        chk("t4c_state", state_o, S_DONE);

        // ---- 5: async reset mid-word ----
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h81);
        step(0, 0, 1, 8'h82);
        step(0, 0, 1, 8'h83);
        RST_X = 1'b0;
        #1;
        chk_reset_vals("t5_async");
        @(posedge WCLK);
        #1;
        chk("t5_enq_in_rst", enq, 1'b0);
        chk("t5_wrst_in_rst", WRST, 1'b0);
        RST_X = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, (i == 2) ? 1'b1 : 1'b0, 1, 8'h90 + 8'(i));
            chk($sformatf("t5_idle_enq_%0d", i), enq, 1'b0);
            chk($sformatf("t5_idle_state_%0d", i), state_o, S_IDLE);
        end
        chk("t5_wcnt", wcnt, 3'd0);
        chk("t5_din", din, 32'h0);
        // Next frame starts clean from lane 0.
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'hC1);
        step(0, 0, 1, 8'hC2);
        step(0, 0, 1, 8'hC3);
        step(0, 0, 1, 8'hC4);
        chk("t5_enq", enq, 1'b1);
        chk("t5_din_new", din, 32'hC4C3C2C1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
